// File: rtl/data_memory_pkg.sv
// Shared definitions for the data memory and its datapath neighbours:
// access-size encodings, ALU control encodings and the store lane-mask helper.
package data_memory_pkg;

    // Access size encodings carried on MemSize
    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_RSVD = 2'b11;

    // ALU control encodings used by the monocycle datapath
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    localparam int unsigned WORD_W = 32;

    // Byte lanes touched by a store of the given size at the given byte offset
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] mask;
        mask = 4'b0000;
        case (size)
            SIZE_BYTE: mask = 4'(4'b0001 << off);
            SIZE_HALF: mask = 4'(4'b0011 << {off[1], 1'b0});
            SIZE_WORD: mask = 4'b1111;
            default:   mask = 4'b0000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/load_aligner.sv
// Selects the addressed byte/halfword from a little-endian memory word and
// sign- or zero-extends it to 32 bits.
// Ports:
//   word        in  32  raw memory word
//   byte_off    in  2   byte address within the word (Addr[1:0])
//   size        in  2   access size (byte/half/word/reserved)
//   is_unsigned in  1   1: zero-extend, 0: sign-extend
//   value       out 32  extended load value (0 for the reserved size)
module load_aligner
    import data_memory_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  byte_off,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] value
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane selection; the halfword uses only bit 1 since bit 0 must be zero when aligned
    always_comb begin
        byte_sel = word[7:0];
        case (byte_off)
            2'd0:    byte_sel = word[7:0];
            2'd1:    byte_sel = word[15:8];
            2'd2:    byte_sel = word[23:16];
            default: byte_sel = word[31:24];
        endcase
        half_sel = byte_off[1] ? word[31:16] : word[15:0];
    end

    // Extension
    always_comb begin
        value = '0;
        case (size)
            SIZE_BYTE: value = {{24{byte_sel[7] & ~is_unsigned}}, byte_sel};
            SIZE_HALF: value = {{16{half_sel[15] & ~is_unsigned}}, half_sel};
            SIZE_WORD: value = word;
            default:   value = '0;
        endcase
    end

endmodule

// File: rtl/data_memory.sv
// Word-organised data RAM with byte/half/word access, combinational loads,
// fault detection and first-fault capture.
// Ports:
//   clk, reset   clock and asynchronous active-high reset
//   MemWrite     store enable (taken on the rising edge)
//   MemRead      load enable (combinational)
//   MemSize      00 byte, 01 half, 10 word, 11 reserved
//   MemUnsigned  zero-extend (1) or sign-extend (0) sub-word loads
//   Addr         byte address
//   WriteData    store data, low bits used for sub-word stores
//   ReadData     combinational load result, 0 unless a clean load
//   Fault        combinational fault on the current access
//   ErrSticky    registered first-fault flag
//   ErrAddr      registered address of the first fault
module data_memory
    import data_memory_pkg::*;
#(
    parameter int unsigned DEPTH          = 256,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic [1:0]  MemSize,
    input  logic        MemUnsigned,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Fault,
    output logic        ErrSticky,
    output logic [31:0] ErrAddr
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WORD_W-1:0] mem [DEPTH];

    logic [AW-1:0]     word_idx;
    logic              access;
    logic              misaligned;
    logic              out_of_range;
    logic              illegal;
    logic              store_en;
    logic [3:0]        lanes;
    logic [WORD_W-1:0] wdata;
    logic [WORD_W-1:0] aligned;

    assign word_idx = Addr[AW+1:2];

    // Fault decode
    always_comb begin
        access       = MemRead | MemWrite;
        misaligned   = ((MemSize == SIZE_HALF) && Addr[0]) ||
                       ((MemSize == SIZE_WORD) && (Addr[1:0] != 2'b00));
        out_of_range = |Addr[31:AW+2];
        illegal      = (MemSize == SIZE_RSVD) || (MemRead && MemWrite);
        Fault        = access & (misaligned | out_of_range | illegal);
    end

    // Store lanes and lane-replicated data so each lane picks its own byte
    always_comb begin
        store_en = MemWrite & ~Fault;
        lanes    = lane_mask(MemSize, Addr[1:0]);
        wdata    = WriteData;
        case (MemSize)
            SIZE_BYTE: wdata = {4{WriteData[7:0]}};
            SIZE_HALF: wdata = {2{WriteData[15:0]}};
            default:   wdata = WriteData;
        endcase
    end

    // Storage: optionally cleared by reset; stores never land while reset is high
    generate
        if (CLEAR_ON_RESET) begin : g_clear
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int i = 0; i < int'(DEPTH); i++) begin
                        mem[AW'(i)] <= '0;
                    end
                end else if (store_en) begin
                    for (int l = 0; l < 4; l++) begin
                        if (lanes[l]) begin
                            mem[word_idx][8*l +: 8] <= wdata[8*l +: 8];
                        end
                    end
                end
            end
        end else begin : g_hold
            always_ff @(posedge clk) begin
                if (!reset && store_en) begin
                    for (int l = 0; l < 4; l++) begin
                        if (lanes[l]) begin
                            mem[word_idx][8*l +: 8] <= wdata[8*l +: 8];
                        end
                    end
                end
            end
        end
    endgenerate

    load_aligner u_load_aligner (
        .word        (mem[word_idx]),
        .byte_off    (Addr[1:0]),
        .size        (MemSize),
        .is_unsigned (MemUnsigned),
        .value       (aligned)
    );

    assign ReadData = (MemRead && !Fault) ? aligned : '0;

    // First-fault capture; later faults leave ErrAddr untouched
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ErrSticky <= 1'b0;
            ErrAddr   <= '0;
        end else if (Fault && !ErrSticky) begin
            ErrSticky <= 1'b1;
            ErrAddr   <= Addr;
        end
    end

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory (DEPTH=256, CLEAR_ON_RESET=1) using a
// byte-array reference model of the memory and fault rules.
module tb_data_memory;

    localparam logic [1:0] SB = 2'b00;
    localparam logic [1:0] SH = 2'b01;
    localparam logic [1:0] SW = 2'b10;
    localparam logic [1:0] SR = 2'b11;
    localparam int unsigned MEM_BYTES = 1024;

    logic        clk;
    logic        reset;
    logic        MemWrite;
    logic        MemRead;
    logic [1:0]  MemSize;
    logic        MemUnsigned;
    logic [31:0] Addr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        Fault;
    logic        ErrSticky;
    logic [31:0] ErrAddr;

    int checks;
    int failures;

    logic [7:0]  mdl [MEM_BYTES];
    logic        m_sticky;
    logic [31:0] m_addr;

    data_memory #(.DEPTH(256), .CLEAR_ON_RESET(1'b1)) dut (
        .clk         (clk),
        .reset       (reset),
        .MemWrite    (MemWrite),
        .MemRead     (MemRead),
        .MemSize     (MemSize),
        .MemUnsigned (MemUnsigned),
        .Addr        (Addr),
        .WriteData   (WriteData),
        .ReadData    (ReadData),
        .Fault       (Fault),
        .ErrSticky   (ErrSticky),
        .ErrAddr     (ErrAddr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == SB) ? 1 : (sz == SH) ? 2 : 4;
    endfunction

    function automatic logic mdl_fault(input logic rd, input logic wr,
                                       input logic [1:0] sz, input logic [31:0] a);
        if (!rd && !wr) return 1'b0;
        if (sz == SR || (rd && wr)) return 1'b1;
        if (a >= MEM_BYTES) return 1'b1;
        if (a % nbytes(sz) != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] mdl_read(input logic rd, input logic wr, input logic [1:0] sz,
                                             input logic uns, input logic [31:0] a);
        logic [31:0] v;
        int n;
        if (!rd || mdl_fault(rd, wr, sz, a)) return 32'h0;
        n = nbytes(sz);
        v = 0;
        for (int k = 0; k < n; k++) v = v | (32'(mdl[a + k]) << (8 * k));
        if (!uns && n < 4 && v[8*n-1]) v = v | ~((32'h1 << (8 * n)) - 1);
        return v;
    endfunction

    task automatic drive(input logic rd, input logic wr, input logic [1:0] sz,
                         input logic uns, input logic [31:0] a, input logic [31:0] wd);
        @(negedge clk);
        MemRead = rd; MemWrite = wr; MemSize = sz; MemUnsigned = uns;
        Addr = a; WriteData = wd;
        #1;
    endtask

    // Advance through a rising edge and apply the same edge to the model
    task automatic edge_update();
        logic f;
        @(posedge clk);
        f = mdl_fault(MemRead, MemWrite, MemSize, Addr);
        if (!reset) begin
            if (MemWrite && !f) begin
                for (int k = 0; k < nbytes(MemSize); k++) mdl[Addr + k] = WriteData[8*k +: 8];
            end
            if (f && !m_sticky) begin
                m_sticky = 1'b1;
                m_addr   = Addr;
            end
        end
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < int'(MEM_BYTES); i++) mdl[i] = 8'h00;
        m_sticky = 1'b0;
        m_addr   = 32'h0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        drive(1, 0, SW, 0, 32'h0, 32'h0);
        checks++;
        if (ErrSticky !== 1'b0 || ErrAddr !== 32'h0) begin
            failures++;
            $display("FAIL reset_err got=%b/%h exp=0/00000000", ErrSticky, ErrAddr);
        end
        checks++;
        if (ReadData !== 32'h0) begin
            failures++;
            $display("FAIL reset_read got=%h exp=00000000", ReadData);
        end
        edge_update();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_word_access();
        drive(0, 1, SW, 0, 32'h10, 32'h8765_4321);
        edge_update();
        drive(1, 0, SW, 0, 32'h10, 32'h0);
        checks++;
        if (ReadData !== 32'h8765_4321 || Fault !== 1'b0) begin
            failures++;
            $display("FAIL lw_0x10 got=%h/%b exp=87654321/0", ReadData, Fault);
        end
        edge_update();
    endtask

    task automatic test_subword_loads();
        logic [1:0]  sz  [4] = '{SB, SB, SH, SH};
        logic        un  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic [31:0] ad  [4] = '{32'h13, 32'h13, 32'h10, 32'h12};
        logic [31:0] ex  [4] = '{32'hFFFF_FF87, 32'h0000_0087, 32'h0000_4321, 32'hFFFF_8765};
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, sz[i], un[i], ad[i], 32'h0);
            checks++;
            if (ReadData !== ex[i] || Fault !== 1'b0) begin
                failures++;
                $display("FAIL subload_%0d got=%h/%b exp=%h/0", i, ReadData, Fault, ex[i]);
            end
            edge_update();
        end
    endtask

    task automatic test_subword_stores();
        drive(0, 1, SB, 0, 32'h11, 32'hFFFF_FFAA);
        edge_update();
        drive(1, 0, SW, 0, 32'h10, 32'h0);
        checks++;
        if (ReadData !== 32'h8765_AA21) begin
            failures++;
            $display("FAIL sb_0x11 got=%h exp=8765aa21", ReadData);
        end
        edge_update();
        drive(0, 1, SH, 0, 32'h12, 32'hABCD_1234);
        edge_update();
        drive(1, 0, SW, 0, 32'h10, 32'h0);
        checks++;
        if (ReadData !== 32'h1234_AA21) begin
            failures++;
            $display("FAIL sh_0x12 got=%h exp=1234aa21", ReadData);
        end
        edge_update();
    endtask

    task automatic test_faults();
        drive(0, 1, SW, 0, 32'h4, 32'h1111_2222);
        edge_update();
        drive(0, 1, SW, 0, 32'h6, 32'hDEAD_BEEF);
        checks++;
        if (Fault !== 1'b1) begin
            failures++;
            $display("FAIL sw_misaligned_fault got=%b exp=1", Fault);
        end
        edge_update();
        checks++;
        if (ErrSticky !== 1'b1 || ErrAddr !== 32'h6) begin
            failures++;
            $display("FAIL first_fault_capture got=%b/%h exp=1/00000006", ErrSticky, ErrAddr);
        end
        drive(1, 0, SW, 0, 32'h4, 32'h0);
        checks++;
        if (ReadData !== 32'h1111_2222) begin
            failures++;
            $display("FAIL misaligned_no_write got=%h exp=11112222", ReadData);
        end
        edge_update();
        drive(1, 0, SW, 0, 32'h400, 32'h0);
        checks++;
        if (Fault !== 1'b1 || ReadData !== 32'h0) begin
            failures++;
            $display("FAIL lw_out_of_range got=%b/%h exp=1/00000000", Fault, ReadData);
        end
        edge_update();
        checks++;
        if (ErrAddr !== 32'h6) begin
            failures++;
            $display("FAIL err_addr_held got=%h exp=00000006", ErrAddr);
        end
    endtask

    task automatic test_illegal();
        drive(1, 0, SW, 0, 32'h0, 32'h0);
        edge_update();
        drive(1, 1, SW, 0, 32'h0, 32'h5555_5555);
        checks++;
        if (Fault !== 1'b1 || ReadData !== 32'h0) begin
            failures++;
            $display("FAIL rd_wr_both got=%b/%h exp=1/00000000", Fault, ReadData);
        end
        edge_update();
        drive(1, 0, SW, 0, 32'h0, 32'h0);
        checks++;
        if (ReadData !== 32'h0) begin
            failures++;
            $display("FAIL rd_wr_no_write got=%h exp=00000000", ReadData);
        end
        edge_update();
        drive(1, 0, SR, 0, 32'h10, 32'h0);
        checks++;
        if (Fault !== 1'b1 || ReadData !== 32'h0) begin
            failures++;
            $display("FAIL reserved_size got=%b/%h exp=1/00000000", Fault, ReadData);
        end
        edge_update();
        drive(0, 0, SW, 0, 32'h7, 32'h0);
        checks++;
        if (Fault !== 1'b0 || ReadData !== 32'h0) begin
            failures++;
            $display("FAIL idle_cycle got=%b/%h exp=0/00000000", Fault, ReadData);
        end
        edge_update();
    endtask

    task automatic test_reset_mid_cycle();
        drive(0, 1, SW, 0, 32'h20, 32'h5A5A_5A5A);
        edge_update();
        @(negedge clk);
        MemRead = 0; MemWrite = 1; MemSize = SW; Addr = 32'h20; WriteData = 32'hDEAD_BEEF;
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        checks++;
        if (ErrSticky !== 1'b0 || ErrAddr !== 32'h0) begin
            failures++;
            $display("FAIL async_reset_err got=%b/%h exp=0/00000000", ErrSticky, ErrAddr);
        end
        edge_update();
        drive(1, 0, SW, 0, 32'h20, 32'h0);
        checks++;
        if (ReadData !== 32'h0) begin
            failures++;
            $display("FAIL cleared_0x20 got=%h exp=00000000", ReadData);
        end
        edge_update();
        drive(0, 1, SW, 0, 32'h20, 32'hCAFE_BABE);
        reset = 1'b0;
        edge_update();
        drive(1, 0, SW, 0, 32'h10, 32'h0);
        checks++;
        if (ReadData !== 32'h0) begin
            failures++;
            $display("FAIL cleared_0x10 got=%h exp=00000000", ReadData);
        end
        edge_update();
        drive(1, 0, SW, 0, 32'h20, 32'h0);
        checks++;
        if (ReadData !== 32'hCAFE_BABE) begin
            failures++;
            $display("FAIL first_store_after_reset got=%h exp=cafebabe", ReadData);
        end
        edge_update();
    endtask

    task automatic test_random();
        logic        rd, wr, uns;
        logic [1:0]  sz;
        logic [31:0] a, wd, exp_rd;
        logic        exp_f;
        int          r;
        for (int it = 0; it < 400; it++) begin
            r  = int'($urandom_range(0, 9));
            rd = (r <= 3) || (r == 8);
            wr = (r >= 4 && r <= 8);
            r  = int'($urandom_range(0, 7));
            sz = (r == 7) ? SR : 2'(r % 3);
            uns = 1'($urandom_range(0, 1));
            a  = ($urandom_range(0, 15) == 0) ? 32'($urandom_range(0, 2047)) : 32'($urandom_range(0, 63));
            wd = $urandom;
            drive(rd, wr, sz, uns, a, wd);
            exp_f  = mdl_fault(rd, wr, sz, a);
            exp_rd = mdl_read(rd, wr, sz, uns, a);
            checks++;
            if (Fault !== exp_f || ReadData !== exp_rd) begin
                failures++;
                $display("FAIL rand_%0d rd=%b wr=%b sz=%b u=%b a=%h got=%b/%h exp=%b/%h",
                         it, rd, wr, sz, uns, a, Fault, ReadData, exp_f, exp_rd);
            end
            edge_update();
            checks++;
            if (ErrSticky !== m_sticky || ErrAddr !== m_addr) begin
                failures++;
                $display("FAIL rand_err_%0d got=%b/%h exp=%b/%h", it, ErrSticky, ErrAddr, m_sticky, m_addr);
            end
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b1;
        MemWrite = 0; MemRead = 0; MemSize = SW; MemUnsigned = 0;
        Addr = 32'h0; WriteData = 32'h0;
        model_reset();
        test_reset();
        test_word_access();
        test_subword_loads();
        test_subword_stores();
        test_faults();
        test_illegal();
        test_reset_mid_cycle();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
